// File: rtl/bcpu_defs.sv
// rtl/bcpu_defs.sv - BCPU16 bus operation encodings and IBUS address-map constants
package bcpu_defs;

    // OBUS write operations issued by the core bus unit.
    typedef enum logic [1:0] {
        OBUSWRITE  = 2'd0,
        OBUSSET    = 2'd1,
        OBUSRESET  = 2'd2,
        OBUSINVERT = 2'd3
    } bus_wr_op_t;

    // IBUS read operations. The wait variants behave as plain reads here;
    // the core re-issues them until its condition is met.
    typedef enum logic [1:0] {
        IBUSREAD       = 2'd0,
        IBUSWAIT0      = 2'd1,
        IBUSWAIT1      = 2'd2,
        BUSOP_RESERVED = 2'd3
    } bus_rd_op_t;

    // Default bus address width of the BCPU16 core.
    localparam int BCPU_BUS_ADDR_WIDTH = 3;

    // MSB of the IBUS address; when set, the read targets the edge latches.
    localparam int IBUS_EDGE_SPACE_BIT = BCPU_BUS_ADDR_WIDTH - 1;

endpackage

// File: rtl/bcpu_bus_input_sync.sv
// rtl/bcpu_bus_input_sync.sv - one input word: synchronizer chain, edge detect, sticky edge latch
//
// Ports:
//   clk, rst_n  - core clock, asynchronous active-low reset
//   edge_en     - 0 suppresses edge detection (warm-up after reset)
//   pins        - asynchronous input word
//   clr_mask    - bits of the edge latch to clear this cycle (read-to-clear)
//   live        - synchronized input word
//   latched     - sticky rising-edge latch word
module bcpu_bus_input_sync #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  edge_en,
    input  logic [DATA_WIDTH-1:0] pins,
    input  logic [DATA_WIDTH-1:0] clr_mask,
    output logic [DATA_WIDTH-1:0] live,
    output logic [DATA_WIDTH-1:0] latched
);

    logic [DATA_WIDTH-1:0] chain [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] rise;

    assign live = chain[SYNC_STAGES-1];
    assign rise = edge_en ? (live & ~prev) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev    <= '0;
            latched <= '0;
        end else begin
            chain[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= live;
            // Set has priority over clear so an edge arriving during the
            // clearing read is kept for the next poll.
            latched <= (latched & ~clr_mask) | rise;
        end
    end

endmodule

// File: rtl/bcpu_bus_port.sv
// rtl/bcpu_bus_port.sv - BCPU16 OBUS/IBUS peripheral responder with GPIO output words and edge latches
//
// Ports:
//   CLK, RESET_N          - core clock, asynchronous active-low reset
//   OBUS_WR_EN/ADDR/OP/MASK/DATA - output word operation (write/set/reset/invert)
//   IBUS_RD_EN/ADDR/OP/MASK      - masked input read request
//   IBUS_RD_DATA/ZF/VALID        - registered read response (1-cycle latency)
//   OUT_PORTS             - flattened output words, word 0 in the LSBs
//   IN_PORTS              - flattened asynchronous input words, word 0 in the LSBs
module bcpu_bus_port
    import bcpu_defs::*;
#(
    parameter int                         ADDR_WIDTH      = BCPU_BUS_ADDR_WIDTH,
    parameter int                         DATA_WIDTH      = 16,
    parameter int                         SYNC_STAGES     = 2,
    parameter logic [DATA_WIDTH-1:0]      OUT_RESET_VALUE = '0
) (
    input  logic                                       CLK,
    input  logic                                       RESET_N,
    input  logic                                       OBUS_WR_EN,
    input  logic [ADDR_WIDTH-1:0]                      OBUS_ADDR,
    input  logic [1:0]                                 OBUS_OP,
    input  logic [DATA_WIDTH-1:0]                      OBUS_MASK,
    input  logic [DATA_WIDTH-1:0]                      OBUS_DATA,
    input  logic                                       IBUS_RD_EN,
    input  logic [ADDR_WIDTH-1:0]                      IBUS_ADDR,
    input  logic [1:0]                                 IBUS_OP,
    input  logic [DATA_WIDTH-1:0]                      IBUS_MASK,
    output logic [DATA_WIDTH-1:0]                      IBUS_RD_DATA,
    output logic                                       IBUS_RD_ZF,
    output logic                                       IBUS_RD_VALID,
    output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]      OUT_PORTS,
    input  logic [DATA_WIDTH*(2**(ADDR_WIDTH-1))-1:0]  IN_PORTS
);

    localparam int OUT_WORDS = 2**ADDR_WIDTH;
    localparam int IN_WORDS  = 2**(ADDR_WIDTH-1);
    localparam int IDX_W     = ADDR_WIDTH - 1;
    localparam int CNT_W     = $clog2(SYNC_STAGES + 2);
    // The edge-space select bit tracks the address MSB for any bus width.
    localparam int EDGE_BIT  = IBUS_EDGE_SPACE_BIT + (ADDR_WIDTH - BCPU_BUS_ADDR_WIDTH);

    function automatic logic [DATA_WIDTH-1:0] apply_wr_op(
        input bus_wr_op_t            op,
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] mask,
        input logic [DATA_WIDTH-1:0] data
    );
        case (op)
            OBUSWRITE: return (word & ~mask) | (data & mask);
            OBUSSET:   return word | mask;
            OBUSRESET: return word & ~mask;
            default:   return word ^ mask;
        endcase
    endfunction

    // ---------------- OBUS: output words ----------------
    logic [DATA_WIDTH-1:0] out_words [OUT_WORDS];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < OUT_WORDS; i++) begin
                out_words[i] <= OUT_RESET_VALUE;
            end
        end else if (OBUS_WR_EN) begin
            out_words[OBUS_ADDR] <= apply_wr_op(bus_wr_op_t'(OBUS_OP), out_words[OBUS_ADDR],
                                                OBUS_MASK, OBUS_DATA);
        end
    end

    for (genvar g = 0; g < OUT_WORDS; g++) begin : g_out
        assign OUT_PORTS[g*DATA_WIDTH +: DATA_WIDTH] = out_words[g];
    end

    // ---------------- Warm-up ----------------
    // Holds off edge detection until the synchronizers and prev registers
    // carry real pin samples, so pins already high at reset raise no event.
    logic [CNT_W-1:0] warm_cnt;
    logic             edge_en;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            warm_cnt <= CNT_W'(SYNC_STAGES + 1);
        end else if (warm_cnt != '0) begin
            warm_cnt <= warm_cnt - CNT_W'(1);
        end
    end

    assign edge_en = (warm_cnt == '0);

    // ---------------- IBUS: input words ----------------
    bus_rd_op_t            rd_op;
    logic                  rd_edge_space;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] live_words [IN_WORDS];
    logic [DATA_WIDTH-1:0] edge_words [IN_WORDS];
    logic [DATA_WIDTH-1:0] clr_masks  [IN_WORDS];

    assign rd_op         = bus_rd_op_t'(IBUS_OP);
    assign rd_edge_space = IBUS_ADDR[EDGE_BIT];
    assign rd_idx        = IBUS_ADDR[IDX_W-1:0];

    for (genvar g = 0; g < IN_WORDS; g++) begin : g_in
        // Every non-reserved read of an edge word clears the bits it returns.
        assign clr_masks[g] = (IBUS_RD_EN && rd_edge_space && rd_op != BUSOP_RESERVED
                               && rd_idx == IDX_W'(g)) ? IBUS_MASK : '0;

        bcpu_bus_input_sync #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (CLK),
            .rst_n    (RESET_N),
            .edge_en  (edge_en),
            .pins     (IN_PORTS[g*DATA_WIDTH +: DATA_WIDTH]),
            .clr_mask (clr_masks[g]),
            .live     (live_words[g]),
            .latched  (edge_words[g])
        );
    end

    logic [DATA_WIDTH-1:0] rd_masked;

    always_comb begin
        rd_masked = '0;
        if (rd_op != BUSOP_RESERVED) begin
            rd_masked = (rd_edge_space ? edge_words[rd_idx] : live_words[rd_idx]) & IBUS_MASK;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            IBUS_RD_DATA  <= '0;
            IBUS_RD_ZF    <= 1'b1;
            IBUS_RD_VALID <= 1'b0;
        end else begin
            IBUS_RD_VALID <= IBUS_RD_EN;
            if (IBUS_RD_EN) begin
                IBUS_RD_DATA <= rd_masked;
                IBUS_RD_ZF   <= (rd_masked == '0);
            end
        end
    end

endmodule

// File: doc/bcpu_bus_port.md
Name: bcpu_bus_port

Overview:
Peripheral-side responder for the BCPU16 OBUS/IBUS protocol.
- OBUS side: holds the output port registers and applies write, set, reset and invert operations issued by the core's bus unit.
- IBUS side: synchronizes the external input ports and serves masked IBUS reads with a 1-cycle registered response.
- Keeps sticky rising-edge event latches that are cleared on read, so IBUSWAIT0/IBUSWAIT1 polling from barrel threads sees every event.
- Sits between the bcpu16 core bus unit and board-level GPIO/peripheral pins.

Parameters:
- ADDR_WIDTH, 3, bus address width. Gives 2**ADDR_WIDTH OBUS words and 2**ADDR_WIDTH IBUS words.
- DATA_WIDTH, 16, bus word width.
- SYNC_STAGES, 2, input synchronizer depth. Must be >= 2.
- OUT_RESET_VALUE, 0, reset value of every OBUS output word.

Ports:
- CLK  in  1  core clock.
- RESET_N  in  1  asynchronous active-low reset.
- OBUS_WR_EN  in  1  write strobe, one cycle per operation.
- OBUS_ADDR  in  ADDR_WIDTH  output word index.
- OBUS_OP  in  2  bus_wr_op_t operation.
- OBUS_MASK  in  DATA_WIDTH  bit mask.
- OBUS_DATA  in  DATA_WIDTH  source data. Used by OBUSWRITE only.
- IBUS_RD_EN  in  1  read strobe.
- IBUS_ADDR  in  ADDR_WIDTH  input word index.
- IBUS_OP  in  2  bus_rd_op_t operation.
- IBUS_MASK  in  DATA_WIDTH  read mask.
- IBUS_RD_DATA  out  DATA_WIDTH  masked read result, registered.
- IBUS_RD_ZF  out  1  1 when IBUS_RD_DATA == 0.
- IBUS_RD_VALID  out  1  response strobe.
- OUT_PORTS  out  DATA_WIDTH*2**ADDR_WIDTH  flattened output words, word 0 in the LSBs.
- IN_PORTS  in  DATA_WIDTH*2**(ADDR_WIDTH-1)  flattened asynchronous inputs, word 0 in the LSBs.

Behaviour:
- Reset (async assert, sync release):
  - OUT_PORTS words = OUT_RESET_VALUE.
  - Synchronizer flops, previous-sample register and edge latches = 0.
  - IBUS_RD_DATA = 0, IBUS_RD_ZF = 1, IBUS_RD_VALID = 0.
  - Warm-up counter = SYNC_STAGES+1.
- Write path, latency 1. On the edge where OBUS_WR_EN=1, word W=OUT[OBUS_ADDR] updates by OBUS_OP:
  - OBUSWRITE: W = (W & ~MASK) | (DATA & MASK).
  - OBUSSET: W = W | MASK.
  - OBUSRESET: W = W & ~MASK.
  - OBUSINVERT: W = W ^ MASK.
  - New value is visible on OUT_PORTS the cycle after the strobe. Back-to-back writes to the same word chain correctly.
- IBUS address map. With H = 2**(ADDR_WIDTH-1):
  - Addresses 0..H-1: live synchronized input word.
  - Addresses H..2H-1: edge latch of input word (addr-H).
- Input path:
  - IN_PORTS pass through a SYNC_STAGES flop chain. A live read reflects a pin change SYNC_STAGES cycles later.
  - Edge detect: rise = sync & ~prev, with prev the registered sync.
  - Edge latch bit sets on rise one cycle after the sync output rises.
  - Edge detect is suppressed while the warm-up counter is nonzero. The counter decrements each cycle to 0, so pins already high at reset produce no event.
- Read path, latency 1. On the edge where IBUS_RD_EN=1:
  - IBUS_RD_VALID=1 for exactly one cycle.
  - IBUS_RD_DATA = source & IBUS_MASK.
  - IBUS_RD_ZF = (IBUS_RD_DATA == 0).
  - For IBUSREAD, IBUSWAIT0 and IBUSWAIT1 on an edge-latch address, the returned masked bits are cleared in the same edge (read-to-clear).
  - BUSOP_RESERVED: data 0, ZF 1, valid 1, no clear.
  - The port does not stall. Wait semantics are implemented by the core re-issuing the read.
- Simultaneous events:
  - Rise and clear on the same bit in the same cycle: latch ends at 1. Set wins and no event is lost. The returned data still shows the old value.
  - Write and read on the same cycle are independent (separate OBUS/IBUS spaces).
- IBUS_RD_DATA holds its last value when IBUS_RD_VALID=0.
- Reset mid-operation: all state returns to reset values immediately. No pending write is applied.

Decomposition:
- bcpu_defs package: bus_wr_op_t and bus_rd_op_t (already present). Add IBUS_EDGE_SPACE_BIT, the MSB of the IBUS address that selects edge latches.
- Sub-module bcpu_bus_input_sync, one instance per input word. Contains the SYNC_STAGES chain, prev register, edge latch with set-priority clear, and the warm-up enable input.
- Warm-up counter and read/write muxing live in the top module.

Test Plan:
- Reset with IN_PORTS word0=0xFFFF held high -> after 10 cycles an edge read at addr 4, mask 0xFFFF returns 0x0000, ZF=1. A live read at addr 0 returns 0xFFFF.
- Write sequence on OUT[2]:
  - OBUSWRITE data 0x1234 mask 0x00FF -> 0x0034.
  - OBUSSET mask 0xF000 -> 0xF034.
  - OBUSINVERT mask 0x0030 -> 0xF004.
  - OBUSRESET mask 0x0004 -> 0xF000.
  - Each value appears 1 cycle after its strobe, and other words are unchanged.
- IN word1 bit3 rises 0->1 -> live read at addr 1 shows 0x0008 after SYNC_STAGES cycles. Edge read at addr 5, mask 0x0008 returns 0x0008, ZF=0. A second identical read returns 0x0000, ZF=1.
- Edge rise on bit0 in the same cycle as a clearing read of bit0 -> that read returns 0. The next read returns 0x0001.
- IBUS_OP=RESERVED on a set edge latch -> data 0, ZF 1, VALID 1, latch still set on a subsequent IBUSREAD.
- Assert RESET_N=0 in the cycle after an OBUSSET strobe -> OUT word = OUT_RESET_VALUE immediately, IBUS_RD_VALID=0.
